// File: rtl/exe_stage.sv
// Execute stage with the EXE-to-MEM pipeline register.
//
// Computes the single-cycle ALU ops combinationally into the output register. MUL, DIVU and
// REMU run iteratively, one step per clock. While a multiply or divide is in progress,
// md_stall holds the upstream stages (PC, IF/ID, ID/EXE) and a bubble is loaded downstream.
//
// Ports:
//   clk, rst_b         clock, asynchronous active-low reset
//   freeze             global pipeline freeze; the output register holds while it is high
//   a, b, control      ALU operands and 4-bit ALU op
//   mem_write, is_LB_SB, cache_en, mem_to_reg, reg_dst, jump, rt_data, pc, inst
//                      controls and data passed through to the MEM stage
//   *_out              registered EXE-to-MEM bundle
//   alu_result_out     registered ALU or mul/div result
//   md_stall           combinational stall request while a mul/div is in progress
module exe_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            freeze,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      control,
  input  logic            mem_write,
  input  logic            is_LB_SB,
  input  logic            cache_en,
  input  logic            mem_to_reg,
  input  logic            reg_dst,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] alu_result_out,
  output logic            mem_write_out,
  output logic            is_LB_SB_out,
  output logic            cache_en_out,
  output logic            mem_to_reg_out,
  output logic            reg_dst_out,
  output logic [1:0]      jump_out,
  output logic [XLEN-1:0] rt_data_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst_out,
  output logic            md_stall
);

  localparam int unsigned CntW = $clog2(MD_CYCLES);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpSlt   = 4'd6,
    OpSltu  = 4'd7,
    OpSll   = 4'd8,
    OpSrl   = 4'd9,
    OpSra   = 4'd10,
    OpLui   = 4'd11,
    OpMul   = 4'd12,
    OpDivu  = 4'd13,
    OpRemu  = 4'd14,
    OpPassB = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } md_state_e;

  alu_op_e   op;
  logic      is_md;
  logic      [4:0] shamt;
  logic      [XLEN-1:0] alu_res;

  md_state_e       state_q;
  alu_op_e         md_op_q;
  logic [CntW-1:0] cnt_q;
  // MUL: ma_q = shifted multiplicand, mb_q = shifted multiplier, acc_q = product.
  // DIVU/REMU: ma_q = dividend shifting out / quotient shifting in, mb_q = divisor,
  // acc_q = partial remainder.
  logic [XLEN-1:0] ma_q;
  logic [XLEN-1:0] mb_q;
  logic [XLEN-1:0] acc_q;

  logic [XLEN-1:0] acc_mul;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] result;

  assign op    = alu_op_e'(control);
  assign is_md = (op == OpMul) || (op == OpDivu) || (op == OpRemu);
  assign shamt = a[4:0];

  // Single-cycle ALU.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OpSll:   alu_res = b << shamt;
      OpSrl:   alu_res = b >> shamt;
      OpSra:   alu_res = $unsigned($signed(b) >>> shamt);
      OpLui:   alu_res = {b[15:0], 16'h0000};
      OpPassB: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step.
  assign acc_mul = acc_q + (mb_q[0] ? ma_q : '0);

  // One restoring-division step. A zero divisor always "fits", which naturally yields an
  // all-ones quotient and leaves the dividend as the remainder.
  assign rem_sh   = {acc_q, ma_q[XLEN-1]};
  assign rem_ge   = rem_sh >= {1'b0, mb_q};
  assign rem_next = rem_ge ? XLEN'(rem_sh - {1'b0, mb_q}) : rem_sh[XLEN-1:0];

  always_comb begin
    md_result = acc_q;
    if (md_op_q == OpDivu) begin
      md_result = ma_q;
    end
  end

  assign md_stall = ((state_q == StIdle) && is_md && !freeze) || (state_q == StBusy);

  // Mul/div sequencer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      md_op_q <= OpAdd;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_md && !freeze) begin
            md_op_q <= op;
            ma_q    <= a;
            mb_q    <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (md_op_q == OpMul) begin
            acc_q <= acc_mul;
            ma_q  <= ma_q << 1;
            mb_q  <= mb_q >> 1;
          end else begin
            acc_q <= rem_next;
            ma_q  <= {ma_q[XLEN-2:0], rem_ge};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(MD_CYCLES - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!freeze) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = (state_q == StDone) ? md_result : alu_res;

  // EXE-to-MEM register: freeze holds, a stall loads a bubble, otherwise load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      alu_result_out <= '0;
      mem_write_out  <= 1'b0;
      is_LB_SB_out   <= 1'b0;
      cache_en_out   <= 1'b0;
      mem_to_reg_out <= 1'b0;
      reg_dst_out    <= 1'b0;
      jump_out       <= '0;
      rt_data_out    <= '0;
      pc_out         <= '0;
      inst_out       <= '0;
    end else if (!freeze) begin
      if (md_stall) begin
        alu_result_out <= '0;
        mem_write_out  <= 1'b0;
        is_LB_SB_out   <= 1'b0;
        cache_en_out   <= 1'b0;
        mem_to_reg_out <= 1'b0;
        reg_dst_out    <= 1'b0;
        jump_out       <= '0;
        rt_data_out    <= '0;
        pc_out         <= '0;
        inst_out       <= '0;
      end else begin
        alu_result_out <= result;
        mem_write_out  <= mem_write;
        is_LB_SB_out   <= is_LB_SB;
        cache_en_out   <= cache_en;
        mem_to_reg_out <= mem_to_reg;
        reg_dst_out    <= reg_dst;
        jump_out       <= jump;
        rt_data_out    <= rt_data;
        pc_out         <= pc;
        inst_out       <= inst;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk;
  logic        rst_b;
  logic        freeze;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic        mem_write;
  logic        is_LB_SB;
  logic        cache_en;
  logic        mem_to_reg;
  logic        reg_dst;
  logic [1:0]  jump;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] alu_result_out;
  logic        mem_write_out;
  logic        is_LB_SB_out;
  logic        cache_en_out;
  logic        mem_to_reg_out;
  logic        reg_dst_out;
  logic [1:0]  jump_out;
  logic [31:0] rt_data_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        md_stall;

  int checks;
  int failures;

  exe_stage dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .freeze         (freeze),
    .a              (a),
    .b              (b),
    .control        (control),
    .mem_write      (mem_write),
    .is_LB_SB       (is_LB_SB),
    .cache_en       (cache_en),
    .mem_to_reg     (mem_to_reg),
    .reg_dst        (reg_dst),
    .jump           (jump),
    .rt_data        (rt_data),
    .pc             (pc),
    .inst           (inst),
    .alu_result_out (alu_result_out),
    .mem_write_out  (mem_write_out),
    .is_LB_SB_out   (is_LB_SB_out),
    .cache_en_out   (cache_en_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_dst_out    (reg_dst_out),
    .jump_out       (jump_out),
    .rt_data_out    (rt_data_out),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .md_stall       (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ins, input logic mw);
    control    = c;
    a          = av;
    b          = bv;
    inst       = ins;
    mem_write  = mw;
    pc         = ins ^ 32'h0040_0000;
    rt_data    = bv;
    is_LB_SB   = 1'b0;
    cache_en   = mw;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    jump       = 2'b00;
  endtask

  task automatic test_reset();
    rst_b  = 1'b0;
    freeze = 1'b0;
    set_in(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    #3;
    checks++;
    if ({alu_result_out, inst_out, pc_out, rt_data_out} !== 128'h0 ||
        {mem_write_out, is_LB_SB_out, cache_en_out, mem_to_reg_out, reg_dst_out, jump_out}
        !== 7'h0) begin
      failures++;
      $display("FAIL reset_outputs: result=%h inst=%h pc=%h required all zero",
               alu_result_out, inst_out, pc_out);
    end
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_md_stall: got %b required 0", md_stall);
    end
    step();
    step();
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [3:0]  c_t [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                              4'd10, 4'd11, 4'd15};
    logic [31:0] a_t [13] = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd31, 32'd4, 32'd4, 32'h0, 32'h1234_5678};
    logic [31:0] b_t [13] = '{32'h1, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                              32'hFF00_FF00, 32'h0, 32'h0, 32'h1, 32'h8000_0000,
                              32'h8000_0000, 32'h0000_ABCD, 32'hDEAD_BEEF};
    logic [31:0] e_t [13] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFF0_FFF0,
                              32'h0FF0_0FF0, 32'h000F_000F, 32'h1, 32'h0, 32'h8000_0000,
                              32'h0800_0000, 32'hF800_0000, 32'hABCD_0000, 32'hDEAD_BEEF};
    logic [5:0] side;
    for (int i = 0; i < 13; i++) begin
      set_in(c_t[i], a_t[i], b_t[i], 32'h1000_0000 + i, i[0]);
      is_LB_SB   = i[1];
      mem_to_reg = i[2];
      reg_dst    = i[3];
      jump       = i[1:0];
      side       = {i[0], i[1], i[0], i[2], i[3], 1'b0};
      step();
      checks++;
      if (alu_result_out !== e_t[i]) begin
        failures++;
        $display("FAIL alu_op%0d: got %h required %h", c_t[i], alu_result_out, e_t[i]);
      end
      checks++;
      if (inst_out !== 32'h1000_0000 + i || pc_out !== ((32'h1000_0000 + i) ^ 32'h0040_0000)
          || rt_data_out !== b_t[i] || jump_out !== i[1:0] ||
          {mem_write_out, is_LB_SB_out, cache_en_out, mem_to_reg_out, reg_dst_out, 1'b0}
          !== side) begin
        failures++;
        $display("FAIL passthru_op%0d: inst=%h pc=%h jump=%b required inst=%h",
                 c_t[i], inst_out, pc_out, jump_out, 32'h1000_0000 + i);
      end
    end
    // Freeze holds the output register even with new inputs.
    freeze = 1'b1;
    set_in(4'd0, 32'h1, 32'h1, 32'h5555_0000, 1'b1);
    step();
    step();
    checks++;
    if (alu_result_out !== 32'hDEAD_BEEF || inst_out !== 32'h1000_000C) begin
      failures++;
      $display("FAIL freeze_hold: result=%h inst=%h required DEADBEEF 1000000c",
               alu_result_out, inst_out);
    end
    freeze = 1'b0;
    set_in(4'd15, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_mul();
    int cnt;
    set_in(4'd12, 32'h0001_2345, 32'h0001_0000, 32'hAAAA_0001, 1'b1);
    #1;
    checks++;
    if (md_stall !== 1'b1) begin
      failures++;
      $display("FAIL mul_stall_start: got %b required 1", md_stall);
    end
    cnt = 0;
    while (md_stall === 1'b1 && cnt < 40) begin
      step();
      cnt++;
      checks++;
      if (inst_out !== 32'h0 || mem_write_out !== 1'b0 || pc_out !== 32'h0) begin
        failures++;
        $display("FAIL mul_bubble: cycle %0d inst=%h mem_write=%b required 0 0",
                 cnt, inst_out, mem_write_out);
      end
    end
    checks++;
    if (cnt != 33) begin
      failures++;
      $display("FAIL mul_stall_len: got %0d required 33", cnt);
    end
    step();
    checks++;
    if (alu_result_out !== 32'h2345_0000 || inst_out !== 32'hAAAA_0001 ||
        mem_write_out !== 1'b1) begin
      failures++;
      $display("FAIL mul_result: got %h inst=%h required 23450000 aaaa0001",
               alu_result_out, inst_out);
    end
    set_in(4'd15, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_divide();
    logic [3:0]  c_t [4] = '{4'd13, 4'd14, 4'd13, 4'd14};
    logic [31:0] a_t [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] b_t [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] e_t [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    int cnt;
    for (int i = 0; i < 4; i++) begin
      set_in(c_t[i], a_t[i], b_t[i], 32'hD000_0000 + i, 1'b0);
      #1;
      cnt = 0;
      while (md_stall === 1'b1 && cnt < 40) begin
        step();
        cnt++;
      end
      checks++;
      if (cnt != 33) begin
        failures++;
        $display("FAIL div%0d_stall_len: got %0d required 33", i, cnt);
      end
      step();
      checks++;
      if (alu_result_out !== e_t[i] || inst_out !== 32'hD000_0000 + i) begin
        failures++;
        $display("FAIL div%0d_result: op=%0d got %h required %h", i, c_t[i],
                 alu_result_out, e_t[i]);
      end
      set_in(4'd15, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
    end
  endtask

  task automatic test_md_freeze();
    int cnt;
    int memw_cnt;
    set_in(4'd12, 32'd3, 32'd5, 32'hBBBB_0001, 1'b0);
    #1;
    cnt = 0;
    while (md_stall === 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt != 33) begin
      failures++;
      $display("FAIL frz_stall_len: got %0d required 33", cnt);
    end
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (alu_result_out !== 32'h0 || inst_out !== 32'h0 || md_stall !== 1'b0) begin
        failures++;
        $display("FAIL frz_hold%0d: result=%h inst=%h stall=%b required 0 0 0",
                 i, alu_result_out, inst_out, md_stall);
      end
    end
    freeze = 1'b0;
    step();
    checks++;
    if (alu_result_out !== 32'd15 || inst_out !== 32'hBBBB_0001) begin
      failures++;
      $display("FAIL frz_capture: got %h inst=%h required 0000000f bbbb0001",
               alu_result_out, inst_out);
    end
    set_in(4'd0, 32'h100, 32'h4, 32'hAC00_0004, 1'b1);
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL frz_sw_stall: got %b required 0", md_stall);
    end
    memw_cnt = 0;
    step();
    checks++;
    if (alu_result_out !== 32'h104 || inst_out !== 32'hAC00_0004) begin
      failures++;
      $display("FAIL frz_sw: got %h inst=%h required 00000104 ac000004",
               alu_result_out, inst_out);
    end
    if (mem_write_out === 1'b1) memw_cnt++;
    set_in(4'd15, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_write_out === 1'b1) memw_cnt++;
    end
    checks++;
    if (memw_cnt != 1) begin
      failures++;
      $display("FAIL frz_sw_once: store seen %0d times required 1", memw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    set_in(4'd13, 32'd100, 32'd7, 32'hD1D1_0001, 1'b0);
    #1;
    cnt = 0;
    while (md_stall === 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    step();
    checks++;
    if (alu_result_out !== 32'd14 || inst_out !== 32'hD1D1_0001) begin
      failures++;
      $display("FAIL b2b_div: got %h inst=%h required 0000000e d1d10001",
               alu_result_out, inst_out);
    end
    set_in(4'd0, 32'd14, 32'd1, 32'hA1A1_0002, 1'b0);
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_add_stall: got %b required 0", md_stall);
    end
    step();
    checks++;
    if (alu_result_out !== 32'd15 || inst_out !== 32'hA1A1_0002) begin
      failures++;
      $display("FAIL b2b_add: got %h inst=%h required 0000000f a1a10002",
               alu_result_out, inst_out);
    end
    set_in(4'd15, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (inst_out !== 32'h0) begin
      failures++;
      $display("FAIL b2b_no_dup: inst=%h required 00000000", inst_out);
    end
  endtask

  task automatic test_reset_mid();
    // Asynchronous clear of a loaded result, between edges.
    set_in(4'd0, 32'd20, 32'd22, 32'hCCCC_0001, 1'b1);
    step();
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (alu_result_out !== 32'h0 || inst_out !== 32'h0 || pc_out !== 32'h0 ||
        mem_write_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: result=%h inst=%h required 0 0", alu_result_out, inst_out);
    end
    step();
    rst_b = 1'b1;
    // Abort a multiply at iteration 10.
    set_in(4'd12, 32'h0001_2345, 32'h0001_0000, 32'hCCCC_0002, 1'b0);
    step();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (md_stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: stall=%b required 1", md_stall);
    end
    #2;
    rst_b = 1'b0;
    set_in(4'd0, 32'd1, 32'd2, 32'hCCCC_0003, 1'b0);
    #1;
    checks++;
    if (alu_result_out !== 32'h0 || inst_out !== 32'h0 || md_stall !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: result=%h inst=%h stall=%b required 0 0 0",
               alu_result_out, inst_out, md_stall);
    end
    step();
    rst_b = 1'b1;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL mid_release_stall: got %b required 0", md_stall);
    end
    step();
    checks++;
    if (alu_result_out !== 32'd3 || inst_out !== 32'hCCCC_0003) begin
      failures++;
      $display("FAIL mid_after: got %h inst=%h required 00000003 cccc0003",
               alu_result_out, inst_out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_mul();
    test_divide();
    test_md_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
